dxi_progress_tracker: RTL and testbench



---
 rtl/dut_tb_param_pkg.sv | 23 ++
 rtl/dxi_progress_ch.sv | 79 +++++++
 rtl/dxi_progress_tracker.sv | 123 ++++++++++++
 tb/tb_dxi_progress_tracker.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_tb_param_pkg.sv
// Shared types and constants for the DXI progress tracker: FSM encoding,
// LFSR polynomial and the slot threshold derived from the active percentage.
package dut_tb_param_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2
    } dxi_trk_state_e;

    localparam int LFSR_W = 16;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic int dxi_thr(input int dist_pct);
        return (dist_pct * 128) / 100;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dxi_progress_ch.sv
// One DXI channel: LFSR-driven slot enable, saturating completion counter
// and milestone sub-counter with a one-cycle pulse output.
module dxi_progress_ch
    import dut_tb_param_pkg::*;
#(
    parameter int          P_DXI_DIST         = 20,
    parameter int          P_MILESTONE_LENGTH = 10,
    parameter int          P_CNT_WIDTH        = 16,
    parameter logic [15:0] P_SEED_CH          = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   clr_i,
    input  logic                   run_i,
    input  logic                   done_i,
    output logic                   active_o,
    output logic                   milestone_o,
    output logic [P_CNT_WIDTH-1:0] cnt_o
);

    localparam logic [7:0] THR_B = 8'(dxi_thr(P_DXI_DIST));
    localparam int MS_W = (P_MILESTONE_LENGTH > 1) ? $clog2(P_MILESTONE_LENGTH) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(P_MILESTONE_LENGTH - 1);

    logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
    logic                   active_q, active_d;
    logic                   mile_q, mile_d;
    logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [MS_W-1:0]        sub_q, sub_d;

    always_comb begin
        lfsr_d   = lfsr_q;
        active_d = 1'b0;
        mile_d   = 1'b0;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        if (clr_i) begin
            lfsr_d = P_SEED_CH;
            cnt_d  = '0;
            sub_d  = '0;
        end else if (run_i) begin
            lfsr_d   = lfsr_next(lfsr_q);
            // zero-extended so that a threshold of 128 admits every value
            active_d = ({1'b0, lfsr_q[15:9]} < THR_B);
            if (done_i) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + P_CNT_WIDTH'(1);
                end
                if (sub_q == MS_LAST) begin
                    sub_d  = '0;
                    mile_d = 1'b1;
                end else begin
                    sub_d = sub_q + MS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lfsr_q   <= P_SEED_CH;
            active_q <= 1'b0;
            mile_q   <= 1'b0;
            cnt_q    <= '0;
            sub_q    <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            active_q <= active_d;
            mile_q   <= mile_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
        end
    end

    assign active_o    = active_q;
    assign milestone_o = mile_q;
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/dxi_progress_tracker.sv
// Multi-channel DXI progress tracker: run/stop FSM, global saturating fail
// counter and per-channel slot/completion trackers.
module dxi_progress_tracker
    import dut_tb_param_pkg::*;
#(
    parameter int          P_CH_NUM           = 4,
    parameter int          P_DXI_DIST         = 20,
    parameter int          P_MILESTONE_LENGTH = 10,
    parameter int          P_MAX_FAIL_NUM     = 16,
    parameter int          P_CNT_WIDTH        = 16,
    parameter logic [15:0] P_SEED             = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  en,
    input  logic                                  clr,
    input  logic [P_CH_NUM-1:0]                   item_done,
    input  logic [P_CH_NUM-1:0]                   item_fail,
    output logic [P_CH_NUM-1:0]                   dxi_active,
    output logic [P_CH_NUM-1:0]                   milestone,
    output logic [P_CH_NUM*P_CNT_WIDTH-1:0]       item_cnt,
    output logic [$clog2(P_MAX_FAIL_NUM+1)-1:0]   fail_cnt,
    output logic                                  stop,
    output logic [1:0]                            state
);

    localparam int FW    = $clog2(P_MAX_FAIL_NUM + 1);
    localparam int PW    = $clog2(P_CH_NUM + 1);
    localparam int SUM_W = FW + PW;
    localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(P_MAX_FAIL_NUM);
    localparam logic [FW-1:0]    MAX_FC  = FW'(P_MAX_FAIL_NUM);

    dxi_trk_state_e state_q, state_d;
    logic [FW-1:0]  fail_cnt_q, fail_cnt_d;
    logic           stop_q, stop_d;
    logic [PW-1:0]  pop;
    logic [SUM_W-1:0] fail_sum;
    logic           run;

    assign run = (state_q == RUN);

    always_comb begin
        pop = '0;
        for (int c = 0; c < P_CH_NUM; c++) begin
            pop = pop + PW'(item_done[c] & item_fail[c]);
        end
    end

    assign fail_sum = SUM_W'(fail_cnt_q) + SUM_W'(pop);

    // Reaching the fail limit wins over a simultaneous en drop
    always_comb begin
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        stop_d     = stop_q;
        if (clr) begin
            state_d    = IDLE;
            fail_cnt_d = '0;
            stop_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (fail_sum >= MAX_SUM) begin
                        fail_cnt_d = MAX_FC;
                        state_d    = STOPPED;
                        stop_d     = 1'b1;
                    end else begin
                        fail_cnt_d = fail_sum[FW-1:0];
                        if (!en) begin
                            state_d = IDLE;
                        end
                    end
                end
                STOPPED: begin
                    state_d = STOPPED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            fail_cnt_q <= '0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_cnt_q <= fail_cnt_d;
            stop_q     <= stop_d;
        end
    end

    for (genvar c = 0; c < P_CH_NUM; c++) begin : g_ch
        dxi_progress_ch #(
            .P_DXI_DIST        (P_DXI_DIST),
            .P_MILESTONE_LENGTH(P_MILESTONE_LENGTH),
            .P_CNT_WIDTH       (P_CNT_WIDTH),
            .P_SEED_CH         (P_SEED ^ 16'(c + 1))
        ) u_ch (
            .clk_i      (clk),
            .rstn_i     (rstn),
            .clr_i      (clr),
            .run_i      (run),
            .done_i     (item_done[c]),
            .active_o   (dxi_active[c]),
            .milestone_o(milestone[c]),
            .cnt_o      (item_cnt[c*P_CNT_WIDTH +: P_CNT_WIDTH])
        );
    end

    assign fail_cnt = fail_cnt_q;
    assign stop     = stop_q;
    assign state    = state_q;

endmodule

// File: tb/tb_dxi_progress_tracker.sv
// Directed bench for dxi_progress_tracker: a default build plus 100% and 0%
// distribution builds with a narrow item counter.
module tb_dxi_progress_tracker;

    logic        clk;
    logic        rstn;
    logic        en, clr;
    logic [3:0]  item_done, item_fail;
    logic [3:0]  dxi_active, milestone;
    logic [63:0] item_cnt;
    logic [4:0]  fail_cnt;
    logic        stop;
    logic [1:0]  state;

    logic        en_b, clr_b;
    logic [3:0]  done_b, fail_b;
    logic [3:0]  act_b, ms_b;
    logic [15:0] cnt_b;
    logic [4:0]  fcnt_b;
    logic        stop_b;
    logic [1:0]  state_b;

    logic [3:0]  act_z, ms_z;
    logic [63:0] cnt_z;
    logic [4:0]  fcnt_z;
    logic        stop_z;
    logic [1:0]  state_z;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] m [4];
    int mism [4];
    int act  [4];

    dxi_progress_tracker dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr),
        .item_done(item_done), .item_fail(item_fail),
        .dxi_active(dxi_active), .milestone(milestone), .item_cnt(item_cnt),
        .fail_cnt(fail_cnt), .stop(stop), .state(state)
    );

    dxi_progress_tracker #(.P_DXI_DIST(100), .P_CNT_WIDTH(4)) dut_b (
        .clk(clk), .rstn(rstn), .en(en_b), .clr(clr_b),
        .item_done(done_b), .item_fail(fail_b),
        .dxi_active(act_b), .milestone(ms_b), .item_cnt(cnt_b),
        .fail_cnt(fcnt_b), .stop(stop_b), .state(state_b)
    );

    dxi_progress_tracker #(.P_DXI_DIST(0)) dut_z (
        .clk(clk), .rstn(rstn), .en(en_b), .clr(clr_b),
        .item_done(done_b), .item_fail(fail_b),
        .dxi_active(act_z), .milestone(ms_z), .item_cnt(cnt_z),
        .fail_cnt(fcnt_z), .stop(stop_z), .state(state_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic seed_model();
        for (int c = 0; c < 4; c++) begin
            m[c]    = 16'hACE1 ^ 16'(c + 1);
            mism[c] = 0;
            act[c]  = 0;
        end
    endtask

    task automatic run_model(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            step();
            for (int c = 0; c < 4; c++) begin
                if (dxi_active[c] !== (m[c][15:9] < 7'd25)) mism[c]++;
                if (dxi_active[c]) act[c]++;
                m[c] = nxt(m[c]);
            end
        end
    endtask

    initial begin
        int np, first_i, second_i, other_ms, bad_b, bad_z;
        rstn = 1'b0; en = 1'b0; clr = 1'b0; item_done = '0; item_fail = '0;
        en_b = 1'b0; clr_b = 1'b0; done_b = '0; fail_b = '0;
        step();
        step();
        chk("rst_state",    64'(state),      64'd0);
        chk("rst_active",   64'(dxi_active), 64'd0);
        chk("rst_milestone",64'(milestone),  64'd0);
        chk("rst_item_cnt", item_cnt,        64'd0);
        chk("rst_fail_cnt", 64'(fail_cnt),   64'd0);
        chk("rst_stop",     64'(stop),       64'd0);
        rstn = 1'b1;
        step();

        // 100% / 0% builds with a 4-bit counter
        en_b = 1'b1;
        step();
        chk("b_state_run",       64'(state_b), 64'd1);
        chk("b_first_run_idle",  64'(act_b),   64'd0);
        step();
        chk("b_active_full",     64'(act_b),   64'hF);
        np = 0; first_i = -1; second_i = -1; bad_b = 0; bad_z = 0;
        for (int i = 0; i < 20; i++) begin
            done_b = 4'b0001;
            step();
            if (ms_b[0]) begin
                np++;
                if (first_i < 0) first_i = i; else second_i = i;
            end
            if (act_b !== 4'hF) bad_b++;
            if (act_z !== 4'h0) bad_z++;
        end
        done_b = '0;
        step();
        chk("b_cnt_saturated", 64'(cnt_b[3:0]), 64'd15);
        chk("b_cnt_other_ch",  64'(cnt_b[15:4]), 64'd0);
        chk("b_ms_count",      64'(np),       64'd2);
        chk("b_ms_first",      64'(first_i),  64'd9);
        chk("b_ms_after_sat",  64'(second_i), 64'd19);
        chk("b_always_active", 64'(bad_b),    64'd0);
        chk("z_never_active",  64'(bad_z),    64'd0);
        chk("z_cnt_ch0",       64'(cnt_z[15:0]), 64'd20);

        // distribution on the default build, exact against an LFSR model
        en = 1'b1;
        step();
        chk("dist_state_run", 64'(state), 64'd1);
        seed_model();
        run_model(10000);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("dist_seq_ch%0d", c), 64'(mism[c]), 64'd0);
            chk($sformatf("dist_band_ch%0d", c),
                64'((act[c] >= 1450) && (act[c] <= 2450)), 64'd1);
        end

        // asynchronous reset mid-run
        rstn = 1'b0;
        #1;
        chk("arst_state",  64'(state),      64'd0);
        chk("arst_active", 64'(dxi_active), 64'd0);
        chk("arst_cnt",    item_cnt,        64'd0);
        chk("arst_stop",   64'(stop),       64'd0);
        rstn = 1'b1;
        step();
        chk("arst_rerun", 64'(state), 64'd1);
        seed_model();
        run_model(50);
        chk("arst_seq_restart", 64'(mism[0] + mism[1] + mism[2] + mism[3]), 64'd0);

        // milestones on channel 1
        np = 0; first_i = -1; second_i = -1; other_ms = 0;
        for (int i = 0; i < 25; i++) begin
            item_done = 4'b0010;
            step();
            if (milestone[1]) begin
                np++;
                if (first_i < 0) first_i = i; else second_i = i;
            end
            if ((milestone & 4'b1101) != 4'b0000) other_ms++;
        end
        item_done = '0;
        step();
        chk("ms_count",     64'(np),       64'd2);
        chk("ms_first",     64'(first_i),  64'd9);
        chk("ms_second",    64'(second_i), 64'd19);
        chk("ms_other_ch",  64'(other_ms), 64'd0);
        chk("ms_cnt_ch1",   64'(item_cnt[31:16]), 64'd25);
        chk("ms_cnt_ch0",   64'(item_cnt[15:0]),  64'd0);
        chk("ms_idle_low",  64'(milestone), 64'd0);

        // fail limit: four channels failing together for four cycles
        for (int k = 0; k < 4; k++) begin
            item_done = 4'hF; item_fail = 4'hF;
            step();
        end
        item_done = '0; item_fail = '0;
        chk("fl_fail_cnt", 64'(fail_cnt), 64'd16);
        chk("fl_stop",     64'(stop),     64'd1);
        chk("fl_state",    64'(state),    64'd2);
        chk("fl_last_counted", 64'(item_cnt[15:0]), 64'd4);
        step();
        chk("fl_active_off", 64'(dxi_active), 64'd0);
        item_done = 4'b0001; item_fail = 4'b0001;
        step();
        item_done = '0; item_fail = '0;
        step();
        chk("fl_fail_held",   64'(fail_cnt),       64'd16);
        chk("fl_cnt_ignored", 64'(item_cnt[15:0]), 64'd4);
        chk("fl_still_stop",  64'(state),          64'd2);

        // clr with en high, then overshoot clamp
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_state", 64'(state),    64'd0);
        chk("clr_fail",  64'(fail_cnt), 64'd0);
        chk("clr_stop",  64'(stop),     64'd0);
        chk("clr_cnt",   item_cnt,      64'd0);
        step();
        chk("clr_rerun", 64'(state), 64'd1);
        for (int k = 0; k < 3; k++) begin
            item_done = 4'hF; item_fail = 4'hF;
            step();
        end
        item_done = 4'b0111; item_fail = 4'b0111;
        step();
        chk("ov_fail_15",  64'(fail_cnt), 64'd15);
        chk("ov_state_run", 64'(state),   64'd1);
        step();
        item_done = '0; item_fail = '0;
        chk("ov_clamped",  64'(fail_cnt), 64'd16);
        chk("ov_stopped",  64'(state),    64'd2);

        // ignored strobes and en hold/resume
        clr = 1'b1; en = 1'b0;
        step();
        clr = 1'b0;
        item_done = 4'hF;
        step();
        step();
        item_done = '0;
        chk("ign_idle_done", item_cnt, 64'd0);
        en = 1'b1;
        step();
        item_fail = 4'hF;
        step();
        item_fail = '0;
        step();
        chk("ign_fail_only_fc",  64'(fail_cnt), 64'd0);
        chk("ign_fail_only_cnt", item_cnt,      64'd0);
        item_done = 4'b0001;
        step();
        item_done = '0; en = 1'b0;
        step();
        chk("hold_state_idle", 64'(state), 64'd0);
        item_done = 4'b0001;
        step();
        step();
        item_done = '0;
        chk("hold_cnt", 64'(item_cnt[15:0]), 64'd1);
        en = 1'b1;
        step();
        item_done = 4'b0001;
        step();
        item_done = '0;
        step();
        chk("resume_cnt", 64'(item_cnt[15:0]), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
